// File: rtl/micro_tlb.sv
// micro_tlb: ENTRIES-way fully-associative translation cache in front of the main TLB.
// Optional perf counters are enabled by defining UTLB_PERF_CNT_EN.
module micro_tlb #(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = 20,
  parameter int PFN_W   = 20,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VPN_W-1:0]  req_vpn,
  input  logic [ASID_W-1:0] req_asid,
  output logic              resp_valid,
  output logic [PFN_W-1:0]  resp_pfn,
  output logic              resp_cached,
  output logic              resp_dirty,
  output logic              resp_miss,
  output logic              resp_invalid,
  output logic              resp_error,
  output logic              mtlb_req,
  output logic [VPN_W-1:0]  mtlb_vpn,
  input  logic              mtlb_ack,
  input  logic              mtlb_hit,
  input  logic              mtlb_valid,
  input  logic              mtlb_dirty,
  input  logic              mtlb_cached,
  input  logic              mtlb_global,
  input  logic              mtlb_error,
  input  logic [PFN_W-1:0]  mtlb_pfn,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               latch_req_s;
  logic [VPN_W-1:0]   req_vpn_q;
  logic [ASID_W-1:0]  req_asid_q;

  logic [ENTRIES-1:0] valid_r;
  logic [VPN_W-1:0]   vpn_r    [ENTRIES];
  logic [ASID_W-1:0]  asid_r   [ENTRIES];
  logic [PFN_W-1:0]   pfn_r    [ENTRIES];
  logic [ENTRIES-1:0] glob_r, cached_r, dirty_r;
  logic [IDX_W-1:0]   rr_ptr_r;

  logic               res_hit_r, res_valid_r, res_dirty_r, res_cached_r, res_error_r;
  logic [PFN_W-1:0]   res_pfn_r;

  logic               match_any_s, lk_hit_s, fill_s, free_any_s;
  logic [IDX_W-1:0]   match_idx_s, free_idx_s, victim_idx_s;

  // Lowest-index invalid slot, returned as {found, index}.
  function automatic logic [IDX_W:0] first_free(input logic [ENTRIES-1:0] v);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!v[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  assign {free_any_s, free_idx_s} = first_free(valid_r);
  assign victim_idx_s = free_any_s ? free_idx_s : rr_ptr_r;
  // A flush in the LOOK cycle forces the lookup down the walk path.
  assign lk_hit_s = (state_r == ST_LOOK) && match_any_s && !flush;
  assign fill_s   = (state_r == ST_WALK) && mtlb_ack && mtlb_hit && mtlb_valid
                    && !mtlb_error && !flush;

  // Associative compare of the latched request against every entry.
  always_comb begin
    match_any_s = 1'b0;
    match_idx_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_r[i] && (vpn_r[i] == req_vpn_q) && (glob_r[i] || (asid_r[i] == req_asid_q))) begin
        match_any_s = 1'b1;
        match_idx_s = IDX_W'(i);
      end else begin
        match_any_s = match_any_s;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s      = state_r;
    latch_req_s  = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_pfn     = '0;
    resp_cached  = 1'b0;
    resp_dirty   = 1'b0;
    resp_miss    = 1'b0;
    resp_invalid = 1'b0;
    resp_error   = 1'b0;
    mtlb_req     = 1'b0;
    mtlb_vpn     = '0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_s     = ST_LOOK;
          latch_req_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOOK: begin
        if (lk_hit_s) begin
          req_ready   = 1'b1;
          resp_valid  = 1'b1;
          resp_pfn    = pfn_r[match_idx_s];
          resp_cached = cached_r[match_idx_s];
          resp_dirty  = dirty_r[match_idx_s];
          if (req_valid) begin
            state_s     = ST_LOOK;
            latch_req_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_WALK;
        end
      end
      ST_WALK: begin
        mtlb_req = 1'b1;
        mtlb_vpn = req_vpn_q;
        if (mtlb_ack) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WALK;
        end
      end
      ST_DONE: begin
        resp_valid   = 1'b1;
        resp_pfn     = res_pfn_r;
        resp_cached  = res_cached_r;
        resp_dirty   = res_dirty_r;
        resp_miss    = !res_hit_r;
        resp_invalid = res_hit_r && !res_valid_r;
        resp_error   = res_error_r;
        state_s      = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, request latch, walk result latch, valid bits and replacement pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      req_vpn_q    <= '0;
      req_asid_q   <= '0;
      res_hit_r    <= 1'b0;
      res_valid_r  <= 1'b0;
      res_dirty_r  <= 1'b0;
      res_cached_r <= 1'b0;
      res_error_r  <= 1'b0;
      res_pfn_r    <= '0;
      valid_r      <= '0;
      rr_ptr_r     <= '0;
    end else begin
      state_r <= state_s;
      if (latch_req_s) begin
        req_vpn_q  <= req_vpn;
        req_asid_q <= req_asid;
      end
      if ((state_r == ST_WALK) && mtlb_ack) begin
        res_hit_r    <= mtlb_hit;
        res_valid_r  <= mtlb_valid;
        res_dirty_r  <= mtlb_dirty;
        res_cached_r <= mtlb_cached;
        res_error_r  <= mtlb_error;
        res_pfn_r    <= mtlb_pfn;
      end
      if (flush) begin
        valid_r <= '0;
      end else if (fill_s) begin
        valid_r[victim_idx_s] <= 1'b1;
      end
      if (fill_s && !free_any_s) begin
        rr_ptr_r <= (rr_ptr_r == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr_r + IDX_W'(1);
      end
    end
  end

  // Entry payload; qualified by valid_r so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      vpn_r[victim_idx_s]    <= req_vpn_q;
      asid_r[victim_idx_s]   <= req_asid_q;
      pfn_r[victim_idx_s]    <= mtlb_pfn;
      glob_r[victim_idx_s]   <= mtlb_global;
      cached_r[victim_idx_s] <= mtlb_cached;
      dirty_r[victim_idx_s]  <= mtlb_dirty;
    end
  end

`ifdef UTLB_PERF_CNT_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (lk_hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) hit_cnt_r <= hit_cnt_r + 32'd1;
      if ((state_r == ST_LOOK) && !lk_hit_s && (miss_cnt_r != 32'hFFFF_FFFF))
        miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_micro_tlb.sv
// Directed self-checking bench for micro_tlb (default 4 entries) with a scripted main-TLB responder.
module tb_micro_tlb;
  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready;
  logic [19:0] req_vpn;
  logic [7:0]  req_asid;
  logic        resp_valid, resp_cached, resp_dirty, resp_miss, resp_invalid, resp_error;
  logic [19:0] resp_pfn;
  logic        mtlb_req, mtlb_ack, mtlb_hit, mtlb_valid, mtlb_dirty, mtlb_cached, mtlb_global, mtlb_error;
  logic [19:0] mtlb_vpn, mtlb_pfn;
  logic [31:0] hit_count, miss_count;

  int tests_run = 0;
  int fails = 0;

  bit          lk_walked, lk_got;
  logic [19:0] lk_pfn, lk_mvpn;
  logic        lk_cached, lk_dirty, lk_miss, lk_inv, lk_err;

  micro_tlb dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_pfn(resp_pfn), .resp_cached(resp_cached), .resp_dirty(resp_dirty),
    .resp_miss(resp_miss), .resp_invalid(resp_invalid), .resp_error(resp_error),
    .mtlb_req(mtlb_req), .mtlb_vpn(mtlb_vpn), .mtlb_ack(mtlb_ack), .mtlb_hit(mtlb_hit),
    .mtlb_valid(mtlb_valid), .mtlb_dirty(mtlb_dirty), .mtlb_cached(mtlb_cached),
    .mtlb_global(mtlb_global), .mtlb_error(mtlb_error), .mtlb_pfn(mtlb_pfn),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vpn = 20'd0; req_asid = 8'd0;
    mtlb_ack = 1'b0; mtlb_hit = 1'b0; mtlb_valid = 1'b0; mtlb_dirty = 1'b0; mtlb_cached = 1'b0;
    mtlb_global = 1'b0; mtlb_error = 1'b0; mtlb_pfn = 20'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One request; on a miss the main TLB acks two cycles after the walk starts.
  task automatic lookup(input logic [19:0] vpn, input logic [7:0] asid,
                        input logic m_hit, input logic m_valid, input logic m_glob,
                        input logic m_cached, input logic m_dirty, input logic m_err,
                        input logic [19:0] m_pfn, input bit fl_look, input bit fl_ack);
    lk_walked = 1'b0; lk_got = 1'b0; lk_pfn = 20'd0; lk_mvpn = 20'd0;
    lk_cached = 1'b0; lk_dirty = 1'b0; lk_miss = 1'b0; lk_inv = 1'b0; lk_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_vpn = vpn; req_asid = asid;
    @(negedge clk);
    req_valid = 1'b0; flush = fl_look;
    #1;
    if (resp_valid) begin
      lk_got = 1'b1; lk_pfn = resp_pfn; lk_cached = resp_cached; lk_dirty = resp_dirty;
      lk_miss = resp_miss; lk_inv = resp_invalid; lk_err = resp_error;
    end else begin
      @(negedge clk);
      flush = 1'b0; lk_walked = mtlb_req; lk_mvpn = mtlb_vpn;
      @(negedge clk);
      mtlb_ack = 1'b1; mtlb_hit = m_hit; mtlb_valid = m_valid; mtlb_global = m_glob;
      mtlb_cached = m_cached; mtlb_dirty = m_dirty; mtlb_error = m_err; mtlb_pfn = m_pfn;
      flush = fl_ack;
      @(negedge clk);
      mtlb_ack = 1'b0; flush = 1'b0;
      #1;
      if (resp_valid) begin
        lk_got = 1'b1; lk_pfn = resp_pfn; lk_cached = resp_cached; lk_dirty = resp_dirty;
        lk_miss = resp_miss; lk_inv = resp_invalid; lk_err = resp_error;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (mtlb_req !== 1'b0) begin fails++; $display("FAIL rst_mtlb_req: got %b expected 0", mtlb_req); end
    tests_run++; if (resp_pfn !== 20'd0) begin fails++; $display("FAIL rst_pfn: got %h expected 0", resp_pfn); end
    tests_run++; if ({hit_count, miss_count} !== 64'd0) begin fails++; $display("FAIL rst_counters: got %h/%h expected 0/0", hit_count, miss_count); end
  endtask

  task automatic test_fill_hit();
    do_reset();
    lookup(20'h00400, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h1F000, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1 || lk_mvpn !== 20'h00400) begin fails++; $display("FAIL fill_walk: got walk=%b vpn=%h expected 1/00400", lk_walked, lk_mvpn); end
    tests_run++; if (lk_got !== 1'b1 || lk_pfn !== 20'h1F000 || lk_cached !== 1'b1) begin fails++; $display("FAIL fill_resp: got v=%b pfn=%h c=%b expected 1/1f000/1", lk_got, lk_pfn, lk_cached); end
    tests_run++; if ({lk_miss, lk_inv, lk_err, lk_dirty} !== 4'b0000) begin fails++; $display("FAIL fill_flags: got %b expected 0000", {lk_miss, lk_inv, lk_err, lk_dirty}); end
    lookup(20'h00400, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b0 || lk_got !== 1'b1 || lk_pfn !== 20'h1F000) begin fails++; $display("FAIL hit_1cyc: got walk=%b v=%b pfn=%h expected 0/1/1f000", lk_walked, lk_got, lk_pfn); end
  endtask

  task automatic test_replacement();
    do_reset();
    for (int i = 0; i < 5; i++)
      lookup(20'h10 + 20'(i), 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h100 + 20'(i), 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      lookup(20'h10 + 20'(i), 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
      tests_run++; if (lk_walked !== 1'b0 || lk_pfn !== 20'h100 + 20'(i) || lk_dirty !== 1'b1) begin fails++; $display("FAIL repl_keep%0d: got walk=%b pfn=%h d=%b expected 0/%h/1", i, lk_walked, lk_pfn, lk_dirty, 20'h100 + 20'(i)); end
    end
    lookup(20'h10, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h200, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1) begin fails++; $display("FAIL repl_evicted: got walk=%b expected 1", lk_walked); end
    lookup(20'h11, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h201, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1) begin fails++; $display("FAIL repl_rr_advance: got walk=%b expected 1", lk_walked); end
  endtask

  task automatic test_asid();
    do_reset();
    lookup(20'h200, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h111, 1'b0, 1'b0);
    lookup(20'h200, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h222, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1 || lk_pfn !== 20'h222) begin fails++; $display("FAIL asid_miss: got walk=%b pfn=%h expected 1/222", lk_walked, lk_pfn); end
    lookup(20'h200, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b0 || lk_pfn !== 20'h111) begin fails++; $display("FAIL asid3_hit: got walk=%b pfn=%h expected 0/111", lk_walked, lk_pfn); end
    lookup(20'h300, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h333, 1'b0, 1'b0);
    lookup(20'h300, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b0 || lk_pfn !== 20'h333) begin fails++; $display("FAIL global_hit: got walk=%b pfn=%h expected 0/333", lk_walked, lk_pfn); end
  endtask

  task automatic test_faults();
    do_reset();
    lookup(20'h400, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h444, 1'b0, 1'b0);
    tests_run++; if ({lk_got, lk_miss, lk_inv, lk_err} !== 4'b1010) begin fails++; $display("FAIL invalid_flags: got %b expected 1010", {lk_got, lk_miss, lk_inv, lk_err}); end
    lookup(20'h400, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h444, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1) begin fails++; $display("FAIL invalid_nofill: got walk=%b expected 1", lk_walked); end
    lookup(20'h401, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    tests_run++; if ({lk_got, lk_miss, lk_inv, lk_err} !== 4'b1100) begin fails++; $display("FAIL miss_flags: got %b expected 1100", {lk_got, lk_miss, lk_inv, lk_err}); end
    lookup(20'h402, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0, 1'b0, 1'b0);
    tests_run++; if ({lk_got, lk_miss, lk_inv, lk_err} !== 4'b1001) begin fails++; $display("FAIL error_flags: got %b expected 1001", {lk_got, lk_miss, lk_inv, lk_err}); end
    lookup(20'h402, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1) begin fails++; $display("FAIL error_nofill: got walk=%b expected 1", lk_walked); end
  endtask

  task automatic test_flush();
    do_reset();
    lookup(20'h500, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h555, 1'b0, 1'b1);
    tests_run++; if (lk_got !== 1'b1 || lk_pfn !== 20'h555) begin fails++; $display("FAIL flush_ack_resp: got v=%b pfn=%h expected 1/555", lk_got, lk_pfn); end
    lookup(20'h500, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h555, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1) begin fails++; $display("FAIL flush_ack_nofill: got walk=%b expected 1", lk_walked); end
    lookup(20'h500, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h556, 1'b1, 1'b0);
    tests_run++; if (lk_walked !== 1'b1 || lk_pfn !== 20'h556) begin fails++; $display("FAIL flush_look_walk: got walk=%b pfn=%h expected 1/556", lk_walked, lk_pfn); end
    lookup(20'h500, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b0 || lk_pfn !== 20'h556) begin fails++; $display("FAIL flush_refill_hit: got walk=%b pfn=%h expected 0/556", lk_walked, lk_pfn); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lookup(20'h600, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h660, 1'b0, 1'b0);
    lookup(20'h601, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h661, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_vpn = 20'h600; req_asid = 8'd5;
    @(negedge clk);
    req_vpn = 20'h601;
    #1;
    tests_run++; if ({resp_valid, req_ready} !== 2'b11 || resp_pfn !== 20'h660) begin fails++; $display("FAIL b2b_first: got v/r=%b pfn=%h expected 11/660", {resp_valid, req_ready}, resp_pfn); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests_run++; if (resp_valid !== 1'b1 || resp_pfn !== 20'h661 || mtlb_req !== 1'b0) begin fails++; $display("FAIL b2b_second: got v=%b pfn=%h mreq=%b expected 1/661/0", resp_valid, resp_pfn, mtlb_req); end
  endtask

  task automatic test_reset_midwalk();
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_vpn = 20'h700; req_asid = 8'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (mtlb_req !== 1'b1) begin fails++; $display("FAIL midwalk_req: got %b expected 1", mtlb_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++; if ({mtlb_req, resp_valid, req_ready} !== 3'b001) begin fails++; $display("FAIL midwalk_abort: got %b expected 001", {mtlb_req, resp_valid, req_ready}); end
    mtlb_ack = 1'b1; mtlb_hit = 1'b1; mtlb_valid = 1'b1; mtlb_pfn = 20'h777;
    @(negedge clk);
    mtlb_ack = 1'b0;
    #1;
    tests_run++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL late_ack_resp: got %b expected 0", resp_valid); end
    lookup(20'h700, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h778, 1'b0, 1'b0);
    tests_run++; if (lk_walked !== 1'b1 || lk_pfn !== 20'h778) begin fails++; $display("FAIL late_ack_nofill: got walk=%b pfn=%h expected 1/778", lk_walked, lk_pfn); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_hit, exp_miss;
    do_reset();
    for (int i = 0; i < 3; i++)
      lookup(20'h800 + 20'(i), 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h880 + 20'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      lookup(20'h800 + 20'(i % 3), 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
`ifdef UTLB_PERF_CNT_EN
    exp_hit = 32'd7; exp_miss = 32'd3;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    @(negedge clk);
    tests_run++; if (hit_count !== exp_hit) begin fails++; $display("FAIL perf_hit: got %0d expected %0d", hit_count, exp_hit); end
    tests_run++; if (miss_count !== exp_miss) begin fails++; $display("FAIL perf_miss: got %0d expected %0d", miss_count, exp_miss); end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_replacement();
    test_asid();
    test_faults();
    test_flush();
    test_back_to_back();
    test_reset_midwalk();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
